// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem, registers IF outputs.
// Ports: clk/rst, stall, redirect_*, im_* (memory side), if_* / halted / fetch_cnt.
module fetch_ctrl #(
  parameter int unsigned         ADDR_W      = 16,
  parameter int unsigned         INSTR_W     = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
  parameter logic [3:0]          HALT_OPCODE = 4'hF,
  parameter logic [INSTR_W-1:0]  NOP_WORD    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  im_addr,
  output logic               im_rd_en,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               if_valid,
  output logic               halted,
  output logic [15:0]        fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pp1_q, pp1_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               redir_take;
  logic               is_hlt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      pp1_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pp1_q    <= pp1_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // BOOT is the memory settle cycle, so a redirect there is not honoured.
  assign redir_take = redirect_valid && (state_q != S_BOOT);
  assign is_hlt = (im_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pp1_d    = pp1_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (redir_take) begin
      state_d  = S_RUN;
      pc_d     = redirect_pc;
      instr_d  = NOP_WORD;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          if (!stall) begin
            instr_d = im_instr;
            pp1_d   = pc_q + 1'b1;
            valid_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            // HLT parks the PC on itself so a restart refetches it.
            if (is_hlt) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
        S_HALT: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  assign im_addr     = pc_q;
  assign im_rd_en    = (state_q == S_RUN) && !stall && !redirect_valid;
  assign if_instr    = instr_q;
  assign if_pc_plus1 = pp1_q;
  assign if_valid    = valid_q;
  assign halted      = halted_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver predicts, monitors compare.
// Memory model latches on the falling edge when im_rd_en is high.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr = '0;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus1;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_rd_en(im_rd_en), .im_instr(im_instr),
    .if_instr(if_instr), .if_pc_plus1(if_pc_plus1),
    .if_valid(if_valid), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [65536];

  always @(negedge clk)
    if (im_rd_en) im_instr <= mem[im_addr];

  typedef struct {
    int          edge_n;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pp1;
    logic        valid;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic        rd;
  } cmb_t;

  exp_t rq[$];
  cmb_t cq[$];

  int n_vec  = 0;
  int n_fail = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n++;

  // Reference model: spec-level machine state.
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  bit          m_known = 0;
  logic [15:0] m_pc, m_instr, m_pp1, m_cnt;
  logic        m_valid, m_halted;

  task automatic cyc(input bit r, input bit s, input bit rv,
                     input logic [15:0] rp);
    cmb_t c;
    exp_t e;
    logic [15:0] w;
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    if (m_known) begin
      c.addr = m_pc;
      c.rd = (m_mode == M_RUN) && !s && !rv;
      cq.push_back(c);
    end
    if (r) begin
      m_known = 1; m_mode = M_BOOT; m_pc = 16'h0000;
      m_instr = 16'h0000; m_pp1 = 16'h0000; m_valid = 0;
      m_halted = 0; m_cnt = 16'h0000;
    end else if (!m_known) begin
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (rv) begin
      m_pc = rp; m_instr = 16'h0000; m_valid = 0;
      m_mode = M_RUN; m_halted = 0;
    end else if (m_mode == M_HALT) begin
      m_instr = 16'h0000; m_valid = 0;
    end else if (!s) begin
      w = mem[m_pc];
      m_instr = w; m_pp1 = m_pc + 16'd1; m_valid = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (w[15:12] == 4'hF) begin
        m_mode = M_HALT; m_halted = 1;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
    if (m_known) begin
      e.edge_n = edge_n + 1;
      e.pc = m_pc; e.instr = m_instr; e.pp1 = m_pp1;
      e.valid = m_valid; e.halted = m_halted; e.cnt = m_cnt;
      rq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    cmb_t c;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      n_vec++;
      if (im_addr !== c.addr || im_rd_en !== c.rd) begin
        n_fail++;
        $display("FAIL comb @%0t: addr=%h rd=%b, expected addr=%h rd=%b",
                 $time, im_addr, im_rd_en, c.addr, c.rd);
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #2;
    while (rq.size() > 0 && rq[0].edge_n <= edge_n) begin
      e = rq.pop_front();
      n_vec++;
      if (im_addr !== e.pc || if_instr !== e.instr ||
          if_pc_plus1 !== e.pp1 || if_valid !== e.valid ||
          halted !== e.halted || fetch_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL regs @%0t: pc=%h ins=%h pp1=%h v=%b h=%b cnt=%h, expected pc=%h ins=%h pp1=%h v=%b h=%b cnt=%h",
                 $time, im_addr, if_instr, if_pc_plus1, if_valid,
                 halted, fetch_cnt, e.pc, e.instr, e.pp1, e.valid,
                 e.halted, e.cnt);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222;
    mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'h6666;
    mem[6] = 16'h7777; mem[7] = 16'hF000;
    mem[16'h0040] = 16'hA040; mem[16'h0041] = 16'hA041;
    mem[16'hFFFF] = 16'hBFFF;

    // reset, boot, fetch to pc=2, stall 3, resume
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    // redirect with simultaneous stall at pc=5
    cyc(0, 1, 1, 16'h0040);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    // run into HLT at 7
    cyc(0, 0, 1, 16'h0005);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, i[0], 0, 0);
    cyc(0, 0, 1, 16'h0003);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    // wrap
    cyc(0, 0, 1, 16'hFFFF);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      cyc(0, k < 4, k == 15, 16'($urandom));
    end
    // reset mid-stall
    cyc(0, 0, 1, 16'h0000);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    // reset during HALT
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    // saturation: strip HLTs and free-run
    for (int i = 0; i < 65536; i++)
      if (mem[i][15:12] == 4'hF) mem[i] = 16'h1234;
    cyc(0, 0, 1, 16'h0100);
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cyc(0, 0, 0, 0);
      guard++;
    end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    @(posedge clk);
    #3;
    n_vec++;
    if (rq.size() != 0 || cq.size() != 0 || m_cnt != 16'hFFFF) begin
      n_fail++;
      $display("FAIL drain: rq=%0d cq=%0d cnt=%h, expected 0 0 ffff",
               rq.size(), cq.size(), m_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
